// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: serialises the core's instruction fetch and data access
// onto one single-ported memory request/response handshake. Requests are
// captured in IDLE. The data side is served first, then the fetch. stall
// stays high until both are complete.
//
// Memory handshake: a request transfers on a rising edge where
// mem_req_valid=1 and mem_req_ready=1. While valid=1 and ready=0, every request
// output holds steady. Read data is taken on an edge where mem_resp_valid=1, and
// only while waiting on a read (D_RESP/I_RESP). mem_resp_valid is ignored in
// every other state.
module cpu_mem_responder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              icache_re,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_re,
  input  logic [3:0]        dcache_we,
  input  logic [31:0]       dcache_din,
  output logic [31:0]       icache_dout,
  output logic [31:0]       dcache_dout,
  output logic              stall,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_rw,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_data,
  output logic [3:0]        mem_req_mask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_data,
  output logic [2:0]        dbg_state,
  output logic [1:0]        dbg_pend
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_REQ  = 3'd1,
    S_D_RESP = 3'd2,
    S_I_REQ  = 3'd3,
    S_I_RESP = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_W-1:2]     r_iaddr;
  logic [ADDR_W-1:2]     r_daddr;
  logic [3:0]            r_we;
  logic [31:0]           r_din;
  logic                  r_d_pend;
  logic                  r_i_pend;
  logic [31:0]           r_icache_dout;
  logic [31:0]           r_dcache_dout;

  logic                  w_cap_d;
  logic                  w_capture;
  logic                  w_d_store;
  logic                  w_unused_addr_lsbs;

  // Byte offsets are irrelevant: memory traffic is always word-aligned.
  assign w_unused_addr_lsbs = ^{icache_addr[1:0], dcache_addr[1:0]};

  assign w_cap_d   = dcache_re | (|dcache_we);
  assign w_capture = (r_state == S_IDLE) && (icache_re || w_cap_d);
  // A nonzero write enable makes the data access a store even if re is also set.
  assign w_d_store = |r_we;

  assign stall       = (r_state != S_IDLE);
  assign icache_dout = r_icache_dout;
  assign dcache_dout = r_dcache_dout;
  assign dbg_state   = r_state;
  assign dbg_pend    = {r_d_pend, r_i_pend};

  // State register; reset aborts any access in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state: data side first, then the fetch if one was captured.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_next_state = w_cap_d ? S_D_REQ : S_I_REQ;
      end
      S_D_REQ: begin
        if (mem_req_ready) begin
          if (w_d_store) w_next_state = r_i_pend ? S_I_REQ : S_IDLE;
          else           w_next_state = S_D_RESP;
        end
      end
      S_D_RESP: begin
        if (mem_resp_valid) w_next_state = r_i_pend ? S_I_REQ : S_IDLE;
      end
      S_I_REQ: begin
        if (mem_req_ready) w_next_state = S_I_RESP;
      end
      S_I_RESP: begin
        if (mem_resp_valid) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Memory request outputs decoded from state and captured registers only,
  // so they cannot move while a request waits for ready.
  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_rw    = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    mem_req_mask  = 4'h0;
    case (r_state)
      S_D_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_daddr, 2'b00};
        if (w_d_store) begin
          mem_req_rw   = 1'b1;
          mem_req_data = r_din;
          mem_req_mask = r_we;
        end else begin
          mem_req_mask = 4'hF;
        end
      end
      S_I_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {r_iaddr, 2'b00};
        mem_req_mask  = 4'hF;
      end
      default: ;
    endcase
  end

  // Capture the core's request in IDLE; the core holds it while stalled anyway.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_iaddr <= '0;
      r_daddr <= '0;
      r_we    <= 4'h0;
      r_din   <= 32'h0;
    end else if (w_capture) begin
      r_iaddr <= icache_addr[ADDR_W-1:2];
      r_daddr <= dcache_addr[ADDR_W-1:2];
      r_we    <= dcache_we;
      r_din   <= dcache_din;
    end
  end

  // Pending flags: set at capture, cleared as each side completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_pend <= 1'b0;
      r_i_pend <= 1'b0;
    end else if (w_capture) begin
      r_d_pend <= w_cap_d;
      r_i_pend <= icache_re;
    end else begin
      if ((r_state == S_D_REQ) && mem_req_ready && w_d_store) r_d_pend <= 1'b0;
      if ((r_state == S_D_RESP) && mem_resp_valid)             r_d_pend <= 1'b0;
      if ((r_state == S_I_RESP) && mem_resp_valid)             r_i_pend <= 1'b0;
    end
  end

  // Read data registers hold until the next read for the same port returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_icache_dout <= 32'h0;
      r_dcache_dout <= 32'h0;
    end else begin
      if ((r_state == S_D_RESP) && mem_resp_valid) r_dcache_dout <= mem_resp_data;
      if ((r_state == S_I_RESP) && mem_resp_valid) r_icache_dout <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Testbench for cpu_mem_responder: a scripted backing memory with configurable
// ready/response wait, directed scenarios with hand-computed expectations.
module tb_cpu_mem_responder;

  logic        clk;
  logic        reset;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] icache_dout;
  logic [31:0] dcache_dout;
  logic        stall;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_rw;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_data;
  logic [3:0]  mem_req_mask;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic [2:0]  dbg_state;
  logic [1:0]  dbg_pend;

  int n_checks = 0;
  int n_errors = 0;

  // Memory model controls and transaction log
  bit          model_en = 0;
  int          ready_wait = 0;
  int          resp_wait = 0;
  int          rdy_cnt;
  int          rsp_cnt;
  bit          rsp_pending;
  logic [31:0] rsp_data;
  logic        log_rw[$];
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];
  logic [3:0]  log_mask[$];

  cpu_mem_responder #(.ADDR_W(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .icache_dout    (icache_dout),
    .dcache_dout    (dcache_dout),
    .stall          (stall),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_rw     (mem_req_rw),
    .mem_req_addr   (mem_req_addr),
    .mem_req_data   (mem_req_data),
    .mem_req_mask   (mem_req_mask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .dbg_state      (dbg_state),
    .dbg_pend       (dbg_pend)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Backing memory contents
  function automatic logic [31:0] mem_rdata(input logic [31:0] a);
    case (a)
      32'h1000_0004: mem_rdata = 32'h0000_0013;
      32'h2000_0000: mem_rdata = 32'hDEAD_BEEF;
      32'h1000_0008: mem_rdata = 32'h0010_0093;
      default:       mem_rdata = 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  // Memory model: decides ready/response at each falling edge for the next rising edge
  initial begin
    rdy_cnt = 0;
    rsp_cnt = 0;
    rsp_pending = 0;
    rsp_data = 32'h0;
    forever begin
      @(negedge clk);
      if (!model_en) begin
        rsp_pending = 0;
        rdy_cnt = ready_wait;
      end else begin
        mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data = 32'h0;
        if (rsp_pending) begin
          if (rsp_cnt == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_data = rsp_data;
            rsp_pending = 0;
          end else begin
            rsp_cnt--;
          end
        end else if (mem_req_valid) begin
          if (rdy_cnt == 0) begin
            mem_req_ready = 1'b1;
            log_rw.push_back(mem_req_rw);
            log_addr.push_back(mem_req_addr);
            log_data.push_back(mem_req_data);
            log_mask.push_back(mem_req_mask);
            if (!mem_req_rw) begin
              rsp_pending = 1;
              rsp_cnt = resp_wait;
              rsp_data = mem_rdata(mem_req_addr);
            end
            rdy_cnt = ready_wait;
          end else begin
            rdy_cnt--;
          end
        end else begin
          rdy_cnt = ready_wait;
        end
      end
    end
  end

  // Driver: present one core request, hold it while stalled, count stall cycles
  task automatic do_access(input logic dre, input logic [3:0] dwe, input logic [31:0] dad,
                           input logic [31:0] din, input logic ire, input logic [31:0] iad,
                           input int rw_wait, input int rsp_w,
                           output int n_stall, output int req_changes);
    logic [68:0] prev;
    logic [68:0] snap;
    bit          have_prev;
    ready_wait = rw_wait;
    resp_wait = rsp_w;
    @(negedge clk);
    log_rw.delete();
    log_addr.delete();
    log_data.delete();
    log_mask.delete();
    dcache_re = dre;
    dcache_we = dwe;
    dcache_addr = dad;
    dcache_din = din;
    icache_re = ire;
    icache_addr = iad;
    @(negedge clk);
    n_stall = 0;
    req_changes = 0;
    have_prev = 0;
    prev = '0;
    while (stall === 1'b1 && n_stall < 50) begin
      n_stall++;
      if (mem_req_valid === 1'b1) begin
        snap = {mem_req_rw, mem_req_addr, mem_req_data, mem_req_mask};
        if (have_prev && snap !== prev) req_changes++;
        prev = snap;
        have_prev = 1;
      end else begin
        have_prev = 0;
      end
      @(negedge clk);
    end
    dcache_re = 1'b0;
    dcache_we = 4'h0;
    icache_re = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      icache_addr = $urandom;
      icache_re = 1'($urandom_range(0, 1));
      dcache_addr = $urandom;
      dcache_re = 1'($urandom_range(0, 1));
      dcache_we = 4'($urandom_range(0, 15));
      dcache_din = $urandom;
      mem_req_ready = 1'($urandom_range(0, 1));
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data = $urandom;
    end
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    n_checks++;
    if (mem_req_valid !== 1'b0 || mem_req_rw !== 1'b0) begin
      n_errors++; $display("FAIL reset_req: valid=%b rw=%b expected 0 0", mem_req_valid, mem_req_rw);
    end
    n_checks++;
    if (mem_req_addr !== 32'h0 || mem_req_data !== 32'h0 || mem_req_mask !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_req_fields: addr=%h data=%h mask=%h expected 0", mem_req_addr, mem_req_data, mem_req_mask);
    end
    n_checks++;
    if (icache_dout !== 32'h0 || dcache_dout !== 32'h0) begin
      n_errors++; $display("FAIL reset_dout: i=%h d=%h expected 0 0", icache_dout, dcache_dout);
    end
    @(negedge clk);
    icache_re = 1'b0;
    dcache_re = 1'b0;
    dcache_we = 4'h0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    reset = 1'b1;
    model_en = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin
        n_errors++; $display("FAIL idle_after_reset: valid=%b stall=%b expected 0 0", mem_req_valid, stall);
      end
    end
    n_checks++;
    if (log_addr.size() != 0) begin
      n_errors++; $display("FAIL idle_no_request: got %0d requests expected 0", log_addr.size());
    end
  endtask

  task automatic test_fetch_only();
    int ns, nc;
    do_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h1000_0006, 0, 0, ns, nc);
    n_checks++;
    if (ns != 2) begin n_errors++; $display("FAIL fetch_stall: got %0d expected 2", ns); end
    n_checks++;
    if (log_addr.size() != 1 || log_addr[0] !== 32'h1000_0004 || log_rw[0] !== 1'b0 || log_mask[0] !== 4'hF) begin
      n_errors++;
      $display("FAIL fetch_req: n=%0d addr=%h rw=%b mask=%h expected 1 10000004 0 f",
               log_addr.size(), log_addr[0], log_rw[0], log_mask[0]);
    end
    n_checks++;
    if (icache_dout !== 32'h0000_0013) begin
      n_errors++; $display("FAIL fetch_dout: got %h expected 00000013", icache_dout);
    end
  endtask

  task automatic test_load_fetch();
    int ns, nc;
    do_access(1'b1, 4'h0, 32'h2000_0000, 32'h0, 1'b1, 32'h1000_0008, 0, 0, ns, nc);
    n_checks++;
    if (ns != 4) begin n_errors++; $display("FAIL load_fetch_stall: got %0d expected 4", ns); end
    n_checks++;
    if (log_addr.size() != 2 || log_addr[0] !== 32'h2000_0000 || log_addr[1] !== 32'h1000_0008 ||
        log_rw[0] !== 1'b0 || log_rw[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL load_fetch_order: n=%0d first=%h second=%h expected 2 20000000 10000008",
               log_addr.size(), log_addr[0], log_addr[1]);
    end
    n_checks++;
    if (dcache_dout !== 32'hDEAD_BEEF || icache_dout !== 32'h0010_0093) begin
      n_errors++; $display("FAIL load_fetch_dout: d=%h i=%h expected deadbeef 00100093", dcache_dout, icache_dout);
    end
  endtask

  task automatic test_store_backpressure();
    int ns, nc;
    do_access(1'b0, 4'b0011, 32'h2000_0012, 32'h1234_5678, 1'b0, 32'h0, 3, 0, ns, nc);
    n_checks++;
    if (ns != 4) begin n_errors++; $display("FAIL store_bp_stall: got %0d expected 4", ns); end
    n_checks++;
    if (nc != 0) begin n_errors++; $display("FAIL store_bp_stable: got %0d changes expected 0", nc); end
    n_checks++;
    if (log_addr.size() != 1 || log_rw[0] !== 1'b1 || log_mask[0] !== 4'b0011 ||
        log_data[0] !== 32'h1234_5678 || log_addr[0] !== 32'h2000_0010) begin
      n_errors++;
      $display("FAIL store_bp_req: n=%0d rw=%b mask=%h data=%h addr=%h expected 1 1 3 12345678 20000010",
               log_addr.size(), log_rw[0], log_mask[0], log_data[0], log_addr[0]);
    end
    n_checks++;
    if (dcache_dout !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL store_bp_dout: got %h expected deadbeef", dcache_dout);
    end
  endtask

  task automatic test_store_priority();
    int ns, nc;
    do_access(1'b1, 4'hF, 32'h2000_0020, 32'hCAFE_F00D, 1'b0, 32'h0, 0, 0, ns, nc);
    n_checks++;
    if (ns != 1) begin n_errors++; $display("FAIL re_we_stall: got %0d expected 1", ns); end
    n_checks++;
    if (log_addr.size() != 1 || log_rw[0] !== 1'b1 || log_mask[0] !== 4'hF || log_data[0] !== 32'hCAFE_F00D) begin
      n_errors++;
      $display("FAIL re_we_store: n=%0d rw=%b mask=%h data=%h expected 1 1 f cafef00d",
               log_addr.size(), log_rw[0], log_mask[0], log_data[0]);
    end
    n_checks++;
    if (dcache_dout !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL re_we_dout: got %h expected deadbeef", dcache_dout);
    end
    // Spurious response while idle
    model_en = 0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h5555_5555;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    @(negedge clk);
    n_checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_errors++; $display("FAIL spurious_state: stall=%b valid=%b expected 0 0", stall, mem_req_valid);
    end
    n_checks++;
    if (dcache_dout !== 32'hDEAD_BEEF || icache_dout !== 32'h0010_0093) begin
      n_errors++; $display("FAIL spurious_dout: d=%h i=%h expected deadbeef 00100093", dcache_dout, icache_dout);
    end
    model_en = 1;
  endtask

  task automatic test_store_fetch();
    int ns, nc;
    do_access(1'b0, 4'b1100, 32'h2000_0031, 32'h0BAD_F00D, 1'b1, 32'h1000_000C, 0, 0, ns, nc);
    n_checks++;
    if (ns != 3) begin n_errors++; $display("FAIL store_fetch_stall: got %0d expected 3", ns); end
    n_checks++;
    if (log_addr.size() != 2 || log_rw[0] !== 1'b1 || log_mask[0] !== 4'b1100 || log_addr[0] !== 32'h2000_0030 ||
        log_rw[1] !== 1'b0 || log_mask[1] !== 4'hF || log_addr[1] !== 32'h1000_000C) begin
      n_errors++;
      $display("FAIL store_fetch_req: n=%0d a0=%h m0=%h a1=%h m1=%h expected 2 20000030 c 1000000c f",
               log_addr.size(), log_addr[0], log_mask[0], log_addr[1], log_mask[1]);
    end
    n_checks++;
    if (icache_dout !== 32'hB5A5_000C || dcache_dout !== 32'hDEAD_BEEF) begin
      n_errors++; $display("FAIL store_fetch_dout: i=%h d=%h expected b5a5000c deadbeef", icache_dout, dcache_dout);
    end
  endtask

  task automatic test_load_waits();
    int ns, nc;
    do_access(1'b1, 4'h0, 32'h2000_0040, 32'h0, 1'b0, 32'h0, 1, 2, ns, nc);
    n_checks++;
    if (ns != 5) begin n_errors++; $display("FAIL load_wait_stall: got %0d expected 5", ns); end
    n_checks++;
    if (dcache_dout !== 32'h85A5_0040 || icache_dout !== 32'hB5A5_000C) begin
      n_errors++; $display("FAIL load_wait_dout: d=%h i=%h expected 85a50040 b5a5000c", dcache_dout, icache_dout);
    end
  endtask

  task automatic test_reset_mid_op();
    model_en = 0;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    // Reset while a data request is being offered
    dcache_re = 1'b1;
    dcache_addr = 32'h3000_0000;
    @(negedge clk);
    n_checks++;
    if (mem_req_valid !== 1'b1 || stall !== 1'b1) begin
      n_errors++; $display("FAIL rst_dreq_pre: valid=%b stall=%b expected 1 1", mem_req_valid, stall);
    end
    #2;
    reset = 1'b0;
    dcache_re = 1'b0;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0 || stall !== 1'b0) begin
      n_errors++; $display("FAIL rst_dreq_async: valid=%b stall=%b expected 0 0", mem_req_valid, stall);
    end
    @(negedge clk);
    reset = 1'b1;
    // Reset while waiting on read data
    dcache_re = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    n_checks++;
    if (dbg_state !== 3'd2 || stall !== 1'b1) begin
      n_errors++; $display("FAIL rst_dresp_pre: state=%0d stall=%b expected 2 1", dbg_state, stall);
    end
    #2;
    reset = 1'b0;
    dcache_re = 1'b0;
    #1;
    n_checks++;
    if (stall !== 1'b0 || mem_req_valid !== 1'b0 || dbg_pend !== 2'b00) begin
      n_errors++; $display("FAIL rst_dresp_async: stall=%b valid=%b pend=%b expected 0 0 00", stall, mem_req_valid, dbg_pend);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hBAD0_BAD0;
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    n_checks++;
    if (icache_dout !== 32'h0 || dcache_dout !== 32'h0) begin
      n_errors++; $display("FAIL rst_late_resp_dout: i=%h d=%h expected 0 0", icache_dout, dcache_dout);
    end
    n_checks++;
    if (stall !== 1'b0) begin n_errors++; $display("FAIL rst_late_resp_stall: got %b expected 0", stall); end
  endtask

  initial begin
    reset = 1'b0;
    icache_addr = 32'h0;
    icache_re = 1'b0;
    dcache_addr = 32'h0;
    dcache_re = 1'b0;
    dcache_we = 4'h0;
    dcache_din = 32'h0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    test_reset();
    test_fetch_only();
    test_load_fetch();
    test_store_backpressure();
    test_store_priority();
    test_store_fetch();
    test_load_waits();
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
